// File: rtl/game_pkg.sv
// Shared types and constants for the round controller: FSM state encoding,
// per-level countdown lengths and point values, and the RESULT hold length.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_PLAY   = 3'd2,
    S_RESULT = 3'd3,
    S_WIN    = 3'd4,
    S_LOSE   = 3'd5
  } state_t;

  localparam logic [5:0] L1_TIME = 6'd30;
  localparam logic [5:0] L2_TIME = 6'd40;
  localparam logic [5:0] L3_TIME = 6'd50;

  localparam logic [9:0] L1_PTS = 10'd100;
  localparam logic [9:0] L2_PTS = 10'd200;
  localparam logic [9:0] L3_PTS = 10'd600;

  localparam int RESULT_HOLD = 2;

  function automatic logic [5:0] level_time(input logic [1:0] lvl);
    case (lvl)
      2'd2:    return L2_TIME;
      2'd3:    return L3_TIME;
      default: return L1_TIME;
    endcase
  endfunction

  function automatic logic [9:0] level_pts(input logic [1:0] lvl);
    case (lvl)
      2'd2:    return L2_PTS;
      2'd3:    return L3_PTS;
      default: return L1_PTS;
    endcase
  endfunction

endpackage

// File: rtl/round_timer.sv
// Loadable 6-bit countdown: load wins over tick, count stops at zero.
// timeout is a same-cycle strobe flagging the tick that takes 1 to 0.
module round_timer
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       tick_en,
  output logic [5:0] count,
  output logic       zero,
  output logic       timeout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 6'd0;
    end else if (load) begin
      count <= load_val;
    end else if (tick_en && (count != 6'd0)) begin
      count <= count - 6'd1;
    end
  end

  assign zero    = (count == 6'd0);
  assign timeout = tick_en && !load && (count == 6'd1);

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: countdown, lives, score and level progression, all outputs registered.
// Optional GAME_TIME_BONUS_EN adds remaining seconds x10 to each correct answer.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT       = 3,
  parameter int ROUNDS_PER_LEVEL = 3,
  parameter int SCORE_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1s,
  input  logic               start,
  input  logic               submit,
  input  logic [7:0]         guess,
  input  logic [7:0]         target,
  input  logic               target_valid,
  output logic               new_target,
  output logic [1:0]         level,
  output logic [5:0]         seconds,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         state,
  output logic               round_ok,
  output logic               round_fail
);

  localparam int         SW1        = SCORE_W + 1;
  localparam logic [2:0] LIVES_FULL = 3'((1 << LIVES_INIT) - 1);
  localparam logic [3:0] ROUNDS_L   = 4'(ROUNDS_PER_LEVEL);
  localparam logic [1:0] HOLD_LAST  = 2'(RESULT_HOLD - 1);

  state_t             state_q, state_d;
  logic [1:0]         level_d;
  logic [2:0]         lives_d;
  logic [SCORE_W-1:0] score_d, score_sat;
  logic [3:0]         rnd_q, rnd_d;
  logic [1:0]         hold_q, hold_d;
  logic [7:0]         tgt_q, tgt_d;
  logic               nt_d, ok_d, fail_d, fail_now;
  logic               t_load, t_tick, t_zero, t_timeout;
  logic [5:0]         t_count;
  logic [SCORE_W:0]   score_sum;

  round_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (level_time(level)),
    .tick_en  (t_tick),
    .count    (t_count),
    .zero     (t_zero),
    .timeout  (t_timeout)
  );

  assign seconds = t_count;
  assign state   = state_q;

`ifdef GAME_TIME_BONUS_EN
  logic [9:0] bonus;
  assign bonus     = {4'd0, t_count} * 10'd10;
  assign score_sum = {1'b0, score} + SW1'(level_pts(level)) + SW1'(bonus);
`else
  assign score_sum = {1'b0, score} + SW1'(level_pts(level));
`endif
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  always_comb begin
    state_d  = state_q;
    level_d  = level;
    lives_d  = lives;
    score_d  = score;
    rnd_d    = rnd_q;
    hold_d   = hold_q;
    tgt_d    = tgt_q;
    nt_d     = 1'b0;
    ok_d     = 1'b0;
    fail_d   = 1'b0;
    fail_now = 1'b0;
    t_load   = 1'b0;
    t_tick   = 1'b0;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_REQ;
          level_d = 2'd1;
          lives_d = LIVES_FULL;
          score_d = '0;
          rnd_d   = 4'd0;
          nt_d    = 1'b1;
        end
      end

      // The cycle showing new_target is the request itself; the handshake starts after it.
      S_REQ: begin
        if (target_valid && !new_target) begin
          tgt_d   = target;
          t_load  = 1'b1;
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        t_tick = tick_1s && !submit && !t_zero;
        if (submit) begin
          if (guess == tgt_q) begin
            score_d = score_sat;
            rnd_d   = rnd_q + 4'd1;
            ok_d    = 1'b1;
            hold_d  = 2'd0;
            state_d = S_RESULT;
          end else begin
            fail_now = 1'b1;
          end
        end else if (t_timeout) begin
          fail_now = 1'b1;
        end
        if (fail_now) begin
          lives_d = lives >> 1;
          fail_d  = 1'b1;
          hold_d  = 2'd0;
          state_d = (lives_d == 3'd0) ? S_LOSE : S_RESULT;
        end
      end

      S_RESULT: begin
        if (tick_1s) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = 2'd0;
            if (rnd_q == ROUNDS_L && level == 2'd3) begin
              state_d = S_WIN;
            end else begin
              if (rnd_q == ROUNDS_L) begin
                level_d = level + 2'd1;
                rnd_d   = 4'd0;
              end
              state_d = S_REQ;
              nt_d    = 1'b1;
            end
          end else begin
            hold_d = hold_q + 2'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      level      <= 2'd1;
      lives      <= 3'd0;
      score      <= '0;
      rnd_q      <= 4'd0;
      hold_q     <= 2'd0;
      tgt_q      <= 8'd0;
      new_target <= 1'b0;
      round_ok   <= 1'b0;
      round_fail <= 1'b0;
    end else begin
      state_q    <= state_d;
      level      <= level_d;
      lives      <= lives_d;
      score      <= score_d;
      rnd_q      <= rnd_d;
      hold_q     <= hold_d;
      tgt_q      <= tgt_d;
      new_target <= nt_d;
      round_ok   <= ok_d;
      round_fail <= fail_d;
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: cycle vector table plus multi-cycle sequences.
// Score expectations follow GAME_TIME_BONUS_EN when it is defined for the build.
module tb_game_round_ctrl;

  logic        clk, reset, tick_1s, start, submit, target_valid;
  logic [7:0]  guess, target;
  logic        new_target, round_ok, round_fail;
  logic [1:0]  level;
  logic [5:0]  seconds;
  logic [2:0]  lives, state;
  logic [15:0] score;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_score;

  game_round_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .tick_1s      (tick_1s),
    .start        (start),
    .submit       (submit),
    .guess        (guess),
    .target       (target),
    .target_valid (target_valid),
    .new_target   (new_target),
    .level        (level),
    .seconds      (seconds),
    .lives        (lives),
    .score        (score),
    .state        (state),
    .round_ok     (round_ok),
    .round_fail   (round_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, st, sub, tck, tv;
    logic [7:0]  g, t;
    logic [2:0]  e_state;
    logic [1:0]  e_level;
    logic [5:0]  e_secs;
    logic [2:0]  e_lives;
    logic [15:0] e_score;
    logic        e_nt, e_ok, e_fail;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pts(input int lvl, input int secs);
    int p;
    p = (lvl == 1) ? 100 : (lvl == 2) ? 200 : 600;
`ifdef GAME_TIME_BONUS_EN
    p = p + secs * 10;
`endif
    return p;
  endfunction

  task automatic pulse_tick();
    tick_1s = 1'b1; cyc(); tick_1s = 1'b0;
  endtask

  task automatic pulse_submit(input logic [7:0] g);
    guess = g; submit = 1'b1; cyc(); submit = 1'b0;
  endtask

  task automatic result_exit();
    pulse_tick();
    pulse_tick();
  endtask

  task automatic to_play(input logic [7:0] t, input int exp_secs);
    logic done;
    done = 1'b0;
    target = t; target_valid = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      cyc();
      if (state == 3'd2) done = 1'b1;
    end
    target_valid = 1'b0;
    chk("enter_play", 32'(done), 32'd1);
    chk("load_secs", 32'(seconds), 32'(exp_secs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick_1s = 0; start = 0; submit = 0; target_valid = 0;
    guess = 8'd0; target = 8'd0;

    //        rst st sb tk tv guess  target  state level secs lives score nt ok fl
    vec[0]  = '{1, 0, 0, 0, 0, 8'd0,  8'd0,  3'd0, 2'd1, 6'd0,  3'd0, 16'd0,   0, 0, 0};
    vec[1]  = '{0, 1, 0, 0, 0, 8'd0,  8'd0,  3'd1, 2'd1, 6'd0,  3'd7, 16'd0,   1, 0, 0};
    vec[2]  = '{0, 0, 0, 0, 1, 8'd0,  8'd37, 3'd1, 2'd1, 6'd0,  3'd7, 16'd0,   0, 0, 0};
    vec[3]  = '{0, 0, 0, 0, 1, 8'd0,  8'd37, 3'd2, 2'd1, 6'd30, 3'd7, 16'd0,   0, 0, 0};
    vec[4]  = '{0, 1, 0, 1, 0, 8'd0,  8'd0,  3'd2, 2'd1, 6'd29, 3'd7, 16'd0,   0, 0, 0};
    vec[5]  = '{0, 0, 1, 1, 0, 8'd37, 8'd0,  3'd3, 2'd1, 6'd29, 3'd7, 16'(pts(1, 29)), 0, 1, 0};
    vec[6]  = '{0, 0, 1, 0, 0, 8'd0,  8'd0,  3'd3, 2'd1, 6'd29, 3'd7, 16'(pts(1, 29)), 0, 0, 0};
    vec[7]  = '{0, 0, 0, 1, 0, 8'd0,  8'd0,  3'd3, 2'd1, 6'd29, 3'd7, 16'(pts(1, 29)), 0, 0, 0};
    vec[8]  = '{0, 0, 0, 1, 0, 8'd0,  8'd0,  3'd1, 2'd1, 6'd29, 3'd7, 16'(pts(1, 29)), 1, 0, 0};
    vec[9]  = '{0, 0, 0, 0, 1, 8'd0,  8'd5,  3'd1, 2'd1, 6'd29, 3'd7, 16'(pts(1, 29)), 0, 0, 0};
    vec[10] = '{0, 0, 0, 0, 1, 8'd0,  8'd5,  3'd2, 2'd1, 6'd30, 3'd7, 16'(pts(1, 29)), 0, 0, 0};
    vec[11] = '{0, 0, 1, 0, 0, 8'd4,  8'd0,  3'd3, 2'd1, 6'd30, 3'd3, 16'(pts(1, 29)), 0, 0, 1};
    vec[12] = '{0, 0, 0, 0, 0, 8'd0,  8'd0,  3'd3, 2'd1, 6'd30, 3'd3, 16'(pts(1, 29)), 0, 0, 0};

    for (int i = 0; i < NV; i++) begin
      reset = vec[i].rst; start = vec[i].st; submit = vec[i].sub;
      tick_1s = vec[i].tck; target_valid = vec[i].tv;
      guess = vec[i].g; target = vec[i].t;
      cyc();
      chk($sformatf("v%0d_state", i), 32'(state),      32'(vec[i].e_state));
      chk($sformatf("v%0d_level", i), 32'(level),      32'(vec[i].e_level));
      chk($sformatf("v%0d_secs", i),  32'(seconds),    32'(vec[i].e_secs));
      chk($sformatf("v%0d_lives", i), 32'(lives),      32'(vec[i].e_lives));
      chk($sformatf("v%0d_score", i), 32'(score),      32'(vec[i].e_score));
      chk($sformatf("v%0d_nt", i),    32'(new_target), 32'(vec[i].e_nt));
      chk($sformatf("v%0d_ok", i),    32'(round_ok),   32'(vec[i].e_ok));
      chk($sformatf("v%0d_fail", i),  32'(round_fail), 32'(vec[i].e_fail));
    end
    reset = 0; start = 0; submit = 0; tick_1s = 0; target_valid = 0;

    // Three wrong answers at level 1 end in LOSE.
    reset = 1'b1; cyc(); reset = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      to_play(8'd37, 30);
      pulse_submit(8'd36);
      chk("lose_fail_pulse", 32'(round_fail), 32'd1);
      chk("lose_lives", 32'(lives), (r == 0) ? 32'd3 : (r == 1) ? 32'd1 : 32'd0);
      chk("lose_state", 32'(state), (r == 2) ? 32'd5 : 32'd3);
      if (r < 2) result_exit();
    end
    pulse_submit(8'd37);
    pulse_tick();
    chk("lose_hold_state", 32'(state), 32'd5);
    chk("lose_frozen_secs", 32'(seconds), 32'd30);
    chk("lose_no_ok", 32'(round_ok), 32'd0);

    // Restart from LOSE, then run out the clock.
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_lives", 32'(lives), 32'd7);
    chk("restart_score", 32'(score), 32'd0);
    exp_score = 0;
    to_play(8'd9, 30);
    tick_1s = 1'b1;
    for (int i = 0; i < 29; i++) cyc();
    chk("tmo_secs_1", 32'(seconds), 32'd1);
    chk("tmo_no_fail_yet", 32'(round_fail), 32'd0);
    cyc();
    tick_1s = 1'b0;
    chk("tmo_secs_0", 32'(seconds), 32'd0);
    chk("tmo_fail_pulse", 32'(round_fail), 32'd1);
    chk("tmo_lives", 32'(lives), 32'd3);
    chk("tmo_state", 32'(state), 32'd3);
    result_exit();

    // Submit coincident with a tick: submit wins, seconds unchanged.
    to_play(8'd9, 30);
    tick_1s = 1'b1; pulse_submit(8'd9); tick_1s = 1'b0;
    exp_score += pts(1, 30);
    chk("coinc_ok", 32'(round_ok), 32'd1);
    chk("coinc_secs", 32'(seconds), 32'd30);
    chk("coinc_score", 32'(score), 32'(exp_score));
    result_exit();

    // Correct answer with 25 s remaining.
    to_play(8'd200, 30);
    for (int i = 0; i < 5; i++) pulse_tick();
    chk("bonus_secs", 32'(seconds), 32'd25);
    pulse_submit(8'd200);
`ifdef GAME_TIME_BONUS_EN
    chk("bonus_delta", 32'(int'(score) - exp_score), 32'd350);
`else
    chk("bonus_delta", 32'(int'(score) - exp_score), 32'd100);
`endif
    result_exit();

    // Reset mid-round at 12 s, with a correct submit in the same cycle.
    to_play(8'd77, 30);
    for (int i = 0; i < 18; i++) pulse_tick();
    chk("rst_pre_secs", 32'(seconds), 32'd12);
    reset = 1'b1; guess = 8'd77; submit = 1'b1; cyc();
    reset = 1'b0; submit = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_secs", 32'(seconds), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_lives", 32'(lives), 32'd0);
    chk("rst_ok", 32'(round_ok), 32'd0);
    chk("rst_fail", 32'(round_fail), 32'd0);

    // Nine correct rounds climb to level 3 and WIN.
    start = 1'b1; cyc(); start = 1'b0;
    exp_score = 0;
    for (int lv = 1; lv <= 3; lv++) begin
      for (int r = 0; r < 3; r++) begin
        to_play(8'(lv * 16 + r), 20 + 10 * lv);
        chk("climb_level", 32'(level), 32'(lv));
        pulse_submit(8'(lv * 16 + r));
        exp_score += pts(lv, 20 + 10 * lv);
        chk("climb_ok", 32'(round_ok), 32'd1);
        chk("climb_score", 32'(score), 32'(exp_score));
        result_exit();
      end
    end
    chk("win_state", 32'(state), 32'd4);
`ifndef GAME_TIME_BONUS_EN
    chk("win_score_2700", 32'(score), 32'd2700);
`endif
    pulse_submit(8'd0);
    chk("win_hold", 32'(state), 32'd4);
    start = 1'b1; cyc(); start = 1'b0;
    chk("win_restart_state", 32'(state), 32'd1);
    chk("win_restart_level", 32'(level), 32'd1);
    chk("win_restart_score", 32'(score), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
